// File: rtl/riscv_program_loader_if.sv
// Byte-stream and instruction-memory bus for the RISC-V program loader.
//
// Purpose : groups the upstream byte-stream handshake and the instruction
//           memory write port into one bundle.
// Signals : byte_valid/byte_data  - upstream byte stream (source -> loader)
//           byte_ready            - loader accepts a byte this cycle
//           imem_we               - one-cycle instruction-memory write strobe
//           imem_addr/imem_wdata  - word-aligned byte address and write data
// Modports: master - the stream source / memory observer side
//           slave  - the loader side
interface riscv_program_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/riscv_program_loader.sv
// RISC-V program loader.
//
// Purpose : receives a little-endian byte stream of the form
//           {word count N, N instruction words, 32-bit checksum}, writes the
//           words into instruction memory starting at BASE_ADDR, verifies the
//           modulo-2^32 sum of the words against the checksum and then either
//           releases the core (done) or aborts (err).
// Ports   : clk, rst    - clock and synchronous active-high reset
//           bus         - slave side of riscv_program_loader_if (byte stream
//                         in, instruction-memory write port out)
//           core_rstn   - active-low core reset, high only once loaded
//           done        - image loaded and verified
//           err         - load aborted (oversize image or bad checksum)
module riscv_program_loader #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  riscv_program_loader_if.slave   bus,
  output logic                    core_rstn,
  output logic                    done,
  output logic                    err
);

  localparam logic [2:0] ST_LEN   = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  localparam logic [31:0] MAX_WORDS = 32'(MEM_WORDS);

  logic [2:0]  state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_idx_q, word_idx_d;
  logic [31:0] len_q, len_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] sum_q, sum_d;
  logic        imem_we_q, imem_we_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic        core_rstn_q, core_rstn_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        byte_ready;
  logic        accept;
  logic        last_byte;
  logic [31:0] word_next;

  // Ready is combinational so that reset blocks acceptance in the same cycle.
  assign byte_ready = !rst && ((state_q == ST_LEN) || (state_q == ST_LOAD) ||
                               (state_q == ST_CHECK));
  assign accept     = bus.byte_valid && byte_ready;
  assign last_byte  = (byte_cnt_q == 2'd3);
  // Bytes shift in from the top so the first byte ends up in bits 7:0.
  assign word_next  = {bus.byte_data, shift_q[31:8]};

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    len_d        = len_q;
    shift_d      = shift_q;
    sum_d        = sum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = word_next;
      if (last_byte) begin
        case (state_q)
          ST_LEN: begin
            len_d      = word_next;
            word_idx_d = 32'd0;
            if (word_next == 32'd0) begin
              state_d = ST_CHECK;
            end else if (word_next > MAX_WORDS) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_LOAD;
            end
          end
          ST_LOAD: begin
            imem_we_d    = 1'b1;
            imem_addr_d  = BASE_ADDR + (word_idx_q << 2);
            imem_wdata_d = word_next;
            sum_d        = sum_q + word_next;
            word_idx_d   = word_idx_q + 32'd1;
            if (word_idx_q == len_q - 32'd1) begin
              state_d = ST_CHECK;
            end
          end
          ST_CHECK: begin
            state_d = (word_next == sum_q) ? ST_RUN : ST_ERROR;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end

    // Status flags are registered from the next state so they rise together
    // with the first cycle spent in RUN or ERROR.
    core_rstn_d = (state_d == ST_RUN);
    done_d      = (state_d == ST_RUN);
    err_d       = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LEN;
      byte_cnt_q   <= 2'd0;
      word_idx_q   <= 32'd0;
      len_q        <= 32'd0;
      shift_q      <= 32'd0;
      sum_q        <= 32'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= 32'd0;
      core_rstn_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      len_q        <= len_d;
      shift_q      <= shift_d;
      sum_q        <= sum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rstn_q  <= core_rstn_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_rstn      = core_rstn_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_riscv_program_loader.sv
// Testbench for riscv_program_loader.
//
// Purpose : drives byte-stream images (directed and random) into the loader.
//           Expected memory writes are queued when an image is issued and a
//           monitor pops and compares them whenever imem_we is seen; final
//           status is predicted from the image's word list and checksum.
module tb_riscv_program_loader;

  localparam int          MEM_WORDS = 16;
  localparam logic [31:0] BASE_ADDR = 32'h0000_2000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  logic core_rstn;
  logic done;
  logic err;

  riscv_program_loader_if bus ();

  riscv_program_loader #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_rstn (core_rstn),
    .done      (done),
    .err       (err)
  );

  wr_t         expQ[$];
  logic [31:0] imgWords[$];
  logic [31:0] imgCks;
  int          compared   = 0;
  int          mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.imem_we === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("write_addr", bus.imem_addr, e.addr);
        checkOutput("write_data", bus.imem_wdata, e.data);
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input int gapPct);
    int waitCnt;
    @(negedge clk);
    while (gapPct > 0 && $urandom_range(99) < gapPct) begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    waitCnt = 0;
    while (!bus.byte_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.byte_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got byte_ready 0 expected 1");
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input int gapPct);
    for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8], gapPct);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst            = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'($urandom);
    #1;
    checkOutput("ready_in_reset", 32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    rst            = 1'b0;
    bus.byte_valid = 1'b0;
    checkOutput("rst_imem_we", 32'(bus.imem_we), 32'd0);
    checkOutput("rst_imem_addr", bus.imem_addr, BASE_ADDR);
    checkOutput("rst_imem_wdata", bus.imem_wdata, 32'd0);
    checkOutput("rst_core_rstn", 32'(core_rstn), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    #1;
    checkOutput("ready_after_reset", 32'(bus.byte_ready), 32'd1);
  endtask

  // Reference model: the image is good iff the payload sum matches the
  // checksum; words land at consecutive word addresses from BASE_ADDR.
  function automatic logic imageGood();
    logic [31:0] s;
    s = 32'd0;
    foreach (imgWords[i]) s = s + imgWords[i];
    return (s == imgCks);
  endfunction

  task automatic checkFinal(input logic expRun, input string tag);
    checkOutput({tag, "_done"}, 32'(done), 32'(expRun));
    checkOutput({tag, "_core_rstn"}, 32'(core_rstn), 32'(expRun));
    checkOutput({tag, "_err"}, 32'(err), 32'(!expRun));
    checkOutput({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
  endtask

  // Issues the current image, queues its expected writes, checks final status
  // one cycle after the last checksum byte.
  task automatic applyStimulus(input int gapPct, input string tag);
    logic expRun;
    expRun = imageGood();
    foreach (imgWords[i]) begin
      wr_t e;
      e.addr = BASE_ADDR + 32'(4 * i);
      e.data = imgWords[i];
      expQ.push_back(e);
    end
    sendWord(32'(imgWords.size()), gapPct);
    foreach (imgWords[i]) sendWord(imgWords[i], gapPct);
    sendWord(imgCks, gapPct);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    checkFinal(expRun, tag);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_writes_pending"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clk);

    doReset();
    imgWords = '{32'h0000_0013, 32'h0010_0093};
    imgCks   = 32'h0010_00A6;
    applyStimulus(0, "good");

    doReset();
    imgCks = 32'h0010_00A7;
    applyStimulus(0, "badcks");

    doReset();
    imgWords.delete();
    imgCks = 32'd0;
    applyStimulus(0, "empty");

    // Oversize length: error right after the length field, nothing accepted after.
    doReset();
    sendWord(32'(MEM_WORDS + 1), 0);
    @(negedge clk);
    checkOutput("oversize_err", 32'(err), 32'd1);
    checkOutput("oversize_done", 32'(done), 32'd0);
    for (int c = 0; c < 6; c++) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom);
      #1;
      checkOutput("oversize_ready", 32'(bus.byte_ready), 32'd0);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    checkOutput("oversize_addr", bus.imem_addr, BASE_ADDR);

    // Reset after 6 payload bytes: word 0 is written, partial word 1 is dropped.
    doReset();
    imgWords = '{32'h0000_0013, 32'h0010_0093};
    imgCks   = 32'h0010_00A6;
    expQ.push_back('{BASE_ADDR, 32'h0000_0013});
    sendWord(32'd2, 0);
    sendWord(32'h0000_0013, 0);
    sendByte(8'h93, 0);
    sendByte(8'h00, 0);
    doReset();
    checkOutput("midload_writes_pending", 32'(expQ.size()), 32'd0);
    applyStimulus(40, "reload");

    // Post-done: stream held valid, nothing accepted or changed.
    for (int c = 0; c < 8; c++) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom);
      #1;
      checkOutput("postdone_ready", 32'(bus.byte_ready), 32'd0);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    checkOutput("postdone_addr", bus.imem_addr, BASE_ADDR + 32'd4);
    checkOutput("postdone_wdata", bus.imem_wdata, 32'h0010_0093);
    checkOutput("postdone_done", 32'(done), 32'd1);

    // Reset while running drops core_rstn on the next edge.
    rst = 1'b1;
    @(negedge clk);
    checkOutput("run_rst_core_rstn", 32'(core_rstn), 32'd0);
    checkOutput("run_rst_done", 32'(done), 32'd0);

    // Random images, including a full-capacity one, with random gaps.
    for (int it = 0; it < 6; it++) begin
      doReset();
      n = (it == 0) ? MEM_WORDS : int'($urandom_range(MEM_WORDS, 1));
      imgWords.delete();
      imgCks = 32'd0;
      for (int i = 0; i < n; i++) begin
        imgWords.push_back($urandom);
        imgCks = imgCks + imgWords[i];
      end
      if ($urandom_range(1) == 1) imgCks = imgCks ^ (32'd1 << $urandom_range(31));
      applyStimulus(int'($urandom_range(50)), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/riscv_program_loader.md
RISCV_PROGRAM_LOADER -- requirements
Module: riscv_program_loader

Interface
REQ-001 Parameter MEM_WORDS, default 1024: instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word; word-aligned.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 byte_valid  input  1  upstream byte-stream valid.
REQ-006 byte_data  input  8  upstream byte.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 imem_we  output  1  instruction-memory write strobe, one-cycle pulse.
REQ-009 imem_addr  output  32  instruction-memory byte address, word-aligned.
REQ-010 imem_wdata  output  32  instruction word to write.
REQ-011 core_rstn  output  1  active-low reset to the datapath; low holds the core.
REQ-012 done  output  1  image loaded and verified; core released.
REQ-013 err  output  1  load aborted; core held.

Function
REQ-014 A byte SHALL be accepted only on an edge where byte_valid and byte_ready are both 1; byte_data is ignored otherwise.
REQ-015 Stream format SHALL be: 4-byte word count N, then N words of 4 bytes each, then a 4-byte checksum; every multi-byte field is little-endian, first byte = bits 7:0.
REQ-016 States SHALL be LEN, LOAD, CHECK, RUN and ERROR; reset enters LEN.
REQ-017 byte_ready SHALL be 1 in LEN, LOAD and CHECK, 0 in RUN and ERROR, and 0 on any cycle where rst is 1.
REQ-018 LEN -> LOAD on acceptance of the 4th length byte when 1 <= N <= MEM_WORDS.
REQ-019 LEN -> CHECK when N = 0.
REQ-020 LEN -> ERROR when N > MEM_WORDS; no memory write occurs.
REQ-021 In LOAD, acceptance of the 4th byte of word i (i = 0..N-1) SHALL produce, on the following cycle only: imem_we = 1, imem_addr = BASE_ADDR + 4*i, imem_wdata = the assembled word.
REQ-022 imem_addr and imem_wdata SHALL hold their last values while imem_we = 0.
REQ-023 The loader SHALL keep a running 32-bit sum of the payload words, modulo 2^32.
REQ-024 LOAD -> CHECK on acceptance of the last byte of word N-1.
REQ-025 In CHECK, on acceptance of the 4th checksum byte: go to RUN if it equals the running sum, else go to ERROR.
REQ-026 No back-pressure SHALL be applied inside LEN, LOAD or CHECK; a byte may be accepted every cycle, including the cycle where imem_we is 1.
REQ-027 Gaps in byte_valid SHALL NOT alter assembly, the byte counter or the checksum.
REQ-028 core_rstn SHALL be 0 in every state except RUN.
REQ-029 core_rstn and done SHALL both rise on the first cycle in RUN and stay 1 until rst.
REQ-030 err SHALL rise on the first cycle in ERROR and stay 1 until rst.
REQ-031 RUN and ERROR SHALL be terminal; only rst leaves them.
REQ-032 All outputs except byte_ready SHALL be registered.

Reset
REQ-033 While rst is 1 on an edge, the loader SHALL enter LEN and clear the byte counter, word index, partial word and checksum.
REQ-034 Reset output values: imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, core_rstn 0, done 0, err 0.
REQ-035 rst asserted mid-load (LEN, LOAD or CHECK) SHALL discard the partial word with no write; memory words already written are not cleared.
REQ-036 rst in RUN SHALL drop core_rstn to 0 on the next edge.

Verification
REQ-037 Good image: N=2, words 0x00000013 and 0x00100093, checksum 0x001000A6, sent back-to-back -> two imem_we pulses (addr 0x0 data 0x00000013; addr 0x4 data 0x00100093), then core_rstn=1, done=1, byte_ready=0.
REQ-038 Bad checksum: same image with checksum 0x001000A7 -> two writes, then err=1, core_rstn=0, done=0, byte_ready=0.
REQ-039 Empty image: N=0, checksum 0 -> no imem_we, done=1 one cycle after the last checksum byte.
REQ-040 Oversize image: N=MEM_WORDS+1 -> err=1 after the 4th length byte, no imem_we, further bytes not accepted.
REQ-041 Reset mid-load: rst after 6 payload bytes, then full reload of the REQ-037 image with random byte_valid gaps -> identical writes and done=1.
REQ-042 Post-done: byte_valid held 1 after done -> byte_ready=0, no imem_we, outputs unchanged.
